// File: rtl/shift_ctrl_if.sv
// Handshake bundle between the main control FSM (master) and the shift sequencer (slave).
// Carries the start/op request and every control output that steers the shift datapath.
interface shift_ctrl_if;
  logic       start;
  logic [2:0] op;
  logic       busy;
  logic [1:0] shift_amt_sel;
  logic       shift_src_sel;
  logic [2:0] shift_cmd;
  logic       reg_write;
  logic       done;
  logic       illegal_op;

  modport master (
    output start, op,
    input  busy, shift_amt_sel, shift_src_sel, shift_cmd, reg_write, done, illegal_op
  );

  modport slave (
    input  start, op,
    output busy, shift_amt_sel, shift_src_sel, shift_cmd, reg_write, done, illegal_op
  );
endinterface

// File: rtl/shift_ctrl.sv
// Multicycle sequencer for the shift datapath: LOAD -> [MEMWAIT] -> SHIFT -> WB.
// Every output is a flop loaded from the decode of the next state and the next latched op.
module shift_ctrl #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic         clk,
  input  logic         reset,
  shift_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_MEMWAIT = 3'd2,
    S_SHIFT   = 3'd3,
    S_WB      = 3'd4
  } state_e;

  localparam logic [2:0] OP_SLLM    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;
  localparam bit         USE_MEMWAIT = (MEM_LAT > 32'd0);
  localparam logic [3:0] CNT_INIT    = USE_MEMWAIT ? 4'(MEM_LAT - 32'd1) : 4'd0;

  // Amount-mux select: imm ops 0..2, regB ops 3..5, mem op 6.
  function automatic logic [1:0] amt_sel_f(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2: amt_sel_f = 2'b01;
      3'd3, 3'd4, 3'd5: amt_sel_f = 2'b00;
      3'd6:             amt_sel_f = 2'b10;
      default:          amt_sel_f = 2'b00;
    endcase
  endfunction

  function automatic logic src_sel_f(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2: src_sel_f = 1'b1;
      default:          src_sel_f = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] shift_cmd_f(input logic [2:0] op);
    case (op)
      3'd0, 3'd3, 3'd6: shift_cmd_f = 3'b010;
      3'd1, 3'd4:       shift_cmd_f = 3'b011;
      3'd2, 3'd5:       shift_cmd_f = 3'b100;
      default:          shift_cmd_f = 3'b000;
    endcase
  endfunction

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic [1:0] amt_sel_q, amt_sel_d;
  logic       src_sel_q, src_sel_d;
  logic [2:0] cmd_q, cmd_d;
  logic       reg_write_q, reg_write_d;
  logic       done_q, done_d;
  logic       illegal_q, illegal_d;

  // Next-state, op latch and MEMWAIT counter.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_ILLEGAL) begin
            illegal_d = 1'b1;
          end else begin
            op_d    = bus.op;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if ((op_q == OP_SLLM) && USE_MEMWAIT) begin
          state_d = S_MEMWAIT;
          cnt_d   = CNT_INIT;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_MEMWAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SHIFT: state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore decode of the upcoming state so the outputs can be registered without extra latency.
  always_comb begin
    busy_d      = 1'b0;
    amt_sel_d   = 2'b00;
    src_sel_d   = 1'b0;
    cmd_d       = 3'b000;
    reg_write_d = 1'b0;
    done_d      = 1'b0;
    if (state_d != S_IDLE) begin
      busy_d    = 1'b1;
      amt_sel_d = amt_sel_f(op_d);
      src_sel_d = src_sel_f(op_d);
    end else begin
      busy_d = 1'b0;
    end
    case (state_d)
      S_LOAD:  cmd_d = 3'b001;
      S_SHIFT: cmd_d = shift_cmd_f(op_d);
      S_WB: begin
        reg_write_d = 1'b1;
        done_d      = 1'b1;
      end
      default: cmd_d = 3'b000;
    endcase
  end

  // State and output registers; reset overrides any pending start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 3'd0;
      cnt_q       <= 4'd0;
      busy_q      <= 1'b0;
      amt_sel_q   <= 2'b00;
      src_sel_q   <= 1'b0;
      cmd_q       <= 3'b000;
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      amt_sel_q   <= amt_sel_d;
      src_sel_q   <= src_sel_d;
      cmd_q       <= cmd_d;
      reg_write_q <= reg_write_d;
      done_q      <= done_d;
      illegal_q   <= illegal_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.shift_amt_sel = amt_sel_q;
  assign bus.shift_src_sel = src_sel_q;
  assign bus.shift_cmd     = cmd_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.done          = done_q;
  assign bus.illegal_op    = illegal_q;

endmodule

// File: tb/tb_shift_ctrl.sv
// Scoreboard bench for shift_ctrl: a timeline model predicts every cycle's outputs and
// a queue of expected done events; a negedge monitor compares the DUT against both.
module tb_shift_ctrl;
  localparam int MEM_LAT = 2;
  localparam int MAXE    = 4096;

  typedef struct {
    int         e;
    logic [2:0] op;
  } item_t;

  logic clk = 1'b0;
  logic reset;
  int   ec = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   free_e = 0;
  item_t      sb_q[$];
  logic [9:0] exp_mem [0:MAXE-1];

  shift_ctrl_if bus();

  shift_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  function automatic logic [9:0] pack(input logic b, input logic [1:0] a, input logic s,
                                      input logic [2:0] c, input logic w, input logic d,
                                      input logic i);
    return {b, a, s, c, w, d, i};
  endfunction

  function automatic logic [1:0] amt_of(input logic [2:0] o);
    if (o <= 3'd2) return 2'b01;
    else if (o <= 3'd5) return 2'b00;
    else return 2'b10;
  endfunction

  function automatic logic [2:0] cmd_of(input logic [2:0] o);
    if (o == 3'd0 || o == 3'd3 || o == 3'd6) return 3'b010;
    else if (o == 3'd1 || o == 3'd4) return 3'b011;
    else return 3'b100;
  endfunction

  // Apply one cycle of stimulus, updating the timeline for the edge that samples it.
  task automatic cyc(input logic r, input logic s, input logic [2:0] o);
    int k;
    int lat;
    logic [1:0] a;
    logic sr;
    k = ec + 1;
    reset = r;
    bus.start = s;
    bus.op = o;
    if (r) begin
      for (int e = k; e < k + 24 && e < MAXE; e++) exp_mem[e] = '0;
      while (sb_q.size() > 0 && sb_q[$].e >= k) void'(sb_q.pop_back());
      free_e = k + 1;
    end else if (s && k >= free_e) begin
      if (o == 3'd7) begin
        exp_mem[k] = pack(1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
      end else begin
        lat = (o == 3'd6) ? MEM_LAT : 0;
        a   = amt_of(o);
        sr  = (o <= 3'd2);
        exp_mem[k] = pack(1'b1, a, sr, 3'b001, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= lat; i++) exp_mem[k + i] = pack(1'b1, a, sr, 3'b000, 1'b0, 1'b0, 1'b0);
        exp_mem[k + lat + 1] = pack(1'b1, a, sr, cmd_of(o), 1'b0, 1'b0, 1'b0);
        exp_mem[k + lat + 2] = pack(1'b1, a, sr, 3'b000, 1'b1, 1'b1, 1'b0);
        sb_q.push_back('{e: k + lat + 2, op: o});
        free_e = k + lat + 4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle output check plus done-event scoreboard.
  always @(negedge clk) begin
    logic [9:0] act;
    item_t it;
    if (ec >= 1 && ec < MAXE) begin
      act = pack(bus.busy, bus.shift_amt_sel, bus.shift_src_sel, bus.shift_cmd,
                 bus.reg_write, bus.done, bus.illegal_op);
      n_cmp++;
      if (act !== exp_mem[ec]) begin
        n_bad++;
        $display("FAIL outputs cycle %0d: got %b expected %b (busy,amt,src,cmd,rw,done,ill)",
                 ec, act, exp_mem[ec]);
      end
      if (bus.done === 1'b1) begin
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL done_unexpected cycle %0d: got done=1 expected no pending op", ec);
        end else begin
          it = sb_q.pop_front();
          if (it.e != ec) begin
            n_bad++;
            $display("FAIL done_timing op %0d: got cycle %0d expected cycle %0d", it.op, ec, it.e);
          end
        end
      end
    end
  end

  initial begin
    logic r, s;
    logic [2:0] o;
    for (int i = 0; i < MAXE; i++) exp_mem[i] = '0;
    // reset held two cycles with start asserted
    cyc(1'b1, 1'b1, 3'd2);
    cyc(1'b1, 1'b1, 3'd2);
    // SRA imm
    cyc(1'b0, 1'b1, 3'd2);
    repeat (4) cyc(1'b0, 1'b0, 3'd0);
    // SLLM through MEMWAIT
    cyc(1'b0, 1'b1, 3'd6);
    repeat (6) cyc(1'b0, 1'b0, 3'd0);
    // illegal op
    cyc(1'b0, 1'b1, 3'd7);
    repeat (2) cyc(1'b0, 1'b0, 3'd0);
    // SRLV with a start pulsed during SHIFT, then a back-to-back start in IDLE
    cyc(1'b0, 1'b1, 3'd4);
    cyc(1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 3'd0);
    cyc(1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b1, 3'd0);
    repeat (5) cyc(1'b0, 1'b0, 3'd0);
    // abort in MEMWAIT
    cyc(1'b0, 1'b1, 3'd6);
    cyc(1'b0, 1'b0, 3'd0);
    cyc(1'b0, 1'b0, 3'd0);
    cyc(1'b1, 1'b0, 3'd0);
    repeat (6) cyc(1'b0, 1'b0, 3'd0);
    // random traffic: op changes every cycle, occasional resets
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 59) == 0);
      s = ($urandom_range(0, 2) == 0);
      o = 3'($urandom_range(0, 7));
      cyc(r, s, o);
    end
    repeat (10) cyc(1'b0, 1'b0, 3'd0);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending done events expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
